// File: rtl/unidade_controle_pkg.sv
// Shared codes, opcodes, FSM states and control-word type for the X/Y/Z
// register datapath control unit.
package unidade_controle_pkg;

  localparam logic [2:0] REG_HOLD   = 3'b000;
  localparam logic [2:0] REG_LOAD   = 3'b001;
  localparam logic [2:0] REG_SHIFTR = 3'b010;
  localparam logic [2:0] REG_SHIFTL = 3'b011;
  localparam logic [2:0] REG_RESET  = 3'b100;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_CLDRD   = 4'b0001;
  localparam logic [3:0] OP_ADDLD   = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_DIV2    = 4'b0100;
  localparam logic [3:0] OP_DISPLAY = 4'b0101;
  localparam logic [3:0] OP_MUL2    = 4'b0110;
  localparam logic [3:0] OP_SUB     = 4'b0111;
  localparam logic [3:0] OP_SHRN    = 4'b1000;
  localparam logic [3:0] OP_SHLN    = 4'b1001;
  localparam logic [3:0] OP_ADDN    = 4'b1010;
  localparam logic [3:0] OP_ADDZ    = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [2:0] tx;
    logic [2:0] ty;
    logic [2:0] tz;
    logic [2:0] tula;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  function automatic ctrl_word_t make_cw(input logic [2:0] tx, input logic [2:0] ty,
                                         input logic [2:0] tz, input logic [2:0] tula);
    ctrl_word_t cw;
    cw.tx   = tx;
    cw.ty   = ty;
    cw.tz   = tz;
    cw.tula = tula;
    return cw;
  endfunction

  localparam ctrl_word_t CW_HOLD = make_cw(REG_HOLD, REG_HOLD, REG_HOLD, ULA_ADD);

endpackage

// File: rtl/decodificador_instr.sv
// Combinational opcode decoder: control word plus repeat/until/legal flags.
// Illegal opcodes decode to an all-HOLD word with both flags cleared.
module decodificador_instr
  import unidade_controle_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0]  i_opcode,
  output logic [CW_W-1:0] o_cw,
  output logic            o_is_repeat,
  output logic            o_is_until,
  output logic            o_legal
);

  logic       w_high_zero;
  logic       w_low_legal;
  logic       w_rep;
  logic       w_until;
  ctrl_word_t w_cw;

  // Bits above the 4-bit base opcode must all be zero for a legal opcode.
  generate
    if (OPW > 4) begin : g_wide
      assign w_high_zero = ~|i_opcode[OPW-1:4];
    end else begin : g_narrow
      assign w_high_zero = 1'b1;
    end
  endgenerate

  // Base opcode table.
  always_comb begin
    w_cw        = CW_HOLD;
    w_rep       = 1'b0;
    w_until     = 1'b0;
    w_low_legal = 1'b1;
    case (i_opcode[3:0])
      OP_NOP:     w_cw = CW_HOLD;
      OP_CLDRD:   w_cw = make_cw(REG_LOAD, REG_RESET, REG_RESET, ULA_ADD);
      OP_ADDLD:   w_cw = make_cw(REG_LOAD, REG_LOAD, REG_HOLD, ULA_ADD);
      OP_ADD:     w_cw = make_cw(REG_HOLD, REG_LOAD, REG_HOLD, ULA_ADD);
      OP_DIV2:    w_cw = make_cw(REG_HOLD, REG_SHIFTR, REG_HOLD, ULA_ADD);
      OP_DISPLAY: w_cw = make_cw(REG_HOLD, REG_HOLD, REG_LOAD, ULA_ADD);
      OP_MUL2:    w_cw = make_cw(REG_HOLD, REG_SHIFTL, REG_HOLD, ULA_ADD);
      OP_SUB:     w_cw = make_cw(REG_HOLD, REG_LOAD, REG_HOLD, ULA_SUB);
      OP_SHRN: begin
        w_cw  = make_cw(REG_HOLD, REG_SHIFTR, REG_HOLD, ULA_ADD);
        w_rep = 1'b1;
      end
      OP_SHLN: begin
        w_cw  = make_cw(REG_HOLD, REG_SHIFTL, REG_HOLD, ULA_ADD);
        w_rep = 1'b1;
      end
      OP_ADDN: begin
        w_cw  = make_cw(REG_HOLD, REG_LOAD, REG_HOLD, ULA_ADD);
        w_rep = 1'b1;
      end
      OP_ADDZ: begin
        w_cw    = make_cw(REG_HOLD, REG_LOAD, REG_HOLD, ULA_ADD);
        w_rep   = 1'b1;
        w_until = 1'b1;
      end
      default: w_low_legal = 1'b0;
    endcase
  end

  assign o_legal     = w_high_zero & w_low_legal;
  assign o_cw        = o_legal ? w_cw : CW_HOLD;
  assign o_is_repeat = o_legal & w_rep;
  assign o_is_until  = o_legal & w_until;

endmodule

// File: rtl/unidade_controle_seq.sv
// Sequenced control unit: accepts one instruction per valid/ready handshake and
// drives registered Tx/Ty/Tz/tula for one or more cycles, then pulses done.
module unidade_controle_seq
  import unidade_controle_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic [CNTW-1:0] arg,
  input  logic            status,
  output logic [2:0]      Tx,
  output logic [2:0]      Ty,
  output logic [2:0]      Tz,
  output logic [2:0]      tula,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  ctrl_word_t      r_cw, w_cw_nxt;
  logic            r_until, w_until_nxt;
  ctrl_word_t      r_out_cw, w_out_cw_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  logic [CW_W-1:0] w_dec_cw_bits;
  ctrl_word_t      w_dec_cw;
  logic            w_dec_repeat;
  logic            w_dec_until;
  logic            w_dec_legal;
  logic            w_accept;

  decodificador_instr #(
    .OPW(OPW)
  ) u_dec (
    .i_opcode   (opcode),
    .o_cw       (w_dec_cw_bits),
    .o_is_repeat(w_dec_repeat),
    .o_is_until (w_dec_until),
    .o_legal    (w_dec_legal)
  );

  assign w_dec_cw = ctrl_word_t'(w_dec_cw_bits);
  assign w_accept = instr_valid & (r_state == ST_IDLE);

  // Next state, counter, latched instruction and the values the output flops take.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cw_nxt     = r_cw;
    w_until_nxt  = r_until;
    w_out_cw_nxt = CW_HOLD;
    w_busy_nxt   = 1'b1;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cw_nxt    = w_dec_cw;
          w_until_nxt = w_dec_until;
          if (!w_dec_legal) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = CNT_ZERO;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (w_dec_repeat && (arg == CNT_ZERO)) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = CNT_ZERO;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_RUN;
            w_cnt_nxt    = w_dec_repeat ? arg : CNT_ONE;
            w_out_cw_nxt = w_dec_cw;
          end
        end else begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        // The word of the cycle that sees status=1 has already been applied.
        if ((r_cnt == CNT_ONE) || (r_until && status)) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_ONE;
          w_out_cw_nxt = r_cw;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, instruction latch and output registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_cw     <= CW_HOLD;
      r_until  <= 1'b0;
      r_out_cw <= CW_HOLD;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cw     <= w_cw_nxt;
      r_until  <= w_until_nxt;
      r_out_cw <= w_out_cw_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign instr_ready = (r_state == ST_IDLE) & ~rst;
  assign Tx   = r_out_cw.tx;
  assign Ty   = r_out_cw.ty;
  assign Tz   = r_out_cw.tz;
  assign tula = r_out_cw.tula;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_unidade_controle_seq.sv
// Bench for unidade_controle_seq: directed and random instructions checked
// cycle by cycle against a per-instruction trace model.
module tb_unidade_controle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid, status;
  logic [3:0] opcode, arg;
  logic       ready, busy, done, err;
  logic [2:0] Tx, Ty, Tz, tula;

  logic       valid6, status6;
  logic [5:0] opcode6;
  logic [3:0] arg6;
  logic       ready6, busy6, done6, err6;
  logic [2:0] Tx6, Ty6, Tz6, tula6;

  int total  = 0;
  int passes = 0;

  unidade_controle_seq #(.OPW(4), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(valid), .instr_ready(ready),
    .opcode(opcode), .arg(arg), .status(status),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .tula(tula),
    .busy(busy), .done(done), .err(err)
  );

  unidade_controle_seq #(.OPW(6), .CNTW(4)) dut6 (
    .clk(clk), .rst(rst), .instr_valid(valid6), .instr_ready(ready6),
    .opcode(opcode6), .arg(arg6), .status(status6),
    .Tx(Tx6), .Ty(Ty6), .Tz(Tz6), .tula(tula6),
    .busy(busy6), .done(done6), .err(err6)
  );

  // Observed vector: {Tx, Ty, Tz, tula, busy, done, err, instr_ready}
  function automatic logic [15:0] obs4();
    return {Tx, Ty, Tz, tula, busy, done, err, ready};
  endfunction

  function automatic logic [15:0] obs6();
    return {Tx6, Ty6, Tz6, tula6, busy6, done6, err6, ready6};
  endfunction

  // Expected {tx, ty, tz, tula} for each legal 4-bit opcode.
  function automatic logic [11:0] model_word(input logic [3:0] op);
    case (op)
      4'd1:    return 12'b001_100_100_000;
      4'd2:    return 12'b001_001_000_000;
      4'd3:    return 12'b000_001_000_000;
      4'd4:    return 12'b000_010_000_000;
      4'd5:    return 12'b000_000_001_000;
      4'd6:    return 12'b000_011_000_000;
      4'd7:    return 12'b000_001_000_001;
      4'd8:    return 12'b000_010_000_000;
      4'd9:    return 12'b000_011_000_000;
      4'd10:   return 12'b000_001_000_000;
      4'd11:   return 12'b000_001_000_000;
      default: return 12'b000_000_000_000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Issue one instruction from IDLE and check every cycle until back in IDLE.
  // rise: RUN cycle index from which status is held 1 (0 = never).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] a, input int rise,
                           input string tag);
    int          n;
    logic        legal;
    logic        rep;
    logic [11:0] w;
    legal = (op < 4'd12);
    rep   = (op >= 4'd8) && (op <= 4'd11);
    if (!legal) n = 0;
    else if (!rep) n = 1;
    else n = int'(a);
    if (legal && op == 4'd11 && rise != 0 && rise < n) n = rise;
    w = legal ? model_word(op) : 12'h000;

    check({tag, ":idle"}, obs4(), 16'b0000_0000_0000_0001);
    valid  = 1'b1;
    opcode = op;
    arg    = a;
    status = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid  = 1'b0;
    opcode = 4'($urandom);
    arg    = 4'($urandom);
    for (int c = 1; c <= n; c++) begin
      check({tag, ":run"}, obs4(), {w, 1'b1, 1'b0, 1'b0, 1'b0});
      status = (rise != 0) && (c >= rise);
      @(negedge clk);
    end
    check({tag, ":done"}, obs4(), {12'h000, 1'b1, 1'b1, ~legal, 1'b0});
    status = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rop, ra;
    rst = 1'b1; valid = 1'b0; opcode = 4'd0; arg = 4'd0; status = 1'b0;
    valid6 = 1'b0; opcode6 = 6'd0; arg6 = 4'd0; status6 = 1'b0;
    @(negedge clk);
    check("reset", obs4(), 16'h0000);
    check("reset6", obs6(), 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    run_instr(4'b0011, 4'd0, 0, "add");
    run_instr(4'b0001, 4'd0, 0, "cldrd");
    run_instr(4'b1000, 4'd3, 0, "shrn3");
    run_instr(4'b1001, 4'd0, 0, "shln0");
    run_instr(4'b1011, 4'd5, 2, "addz_rise2");
    run_instr(4'b1011, 4'd5, 0, "addz_hold0");
    run_instr(4'b1011, 4'd3, 1, "addz_rise1");
    run_instr(4'b1110, 4'd0, 0, "illegal");
    run_instr(4'b0000, 4'd7, 0, "nop");
    run_instr(4'b1010, 4'd15, 0, "addn_max");

    // Reset during the 2nd RUN cycle of SHLN x4 aborts without a done pulse.
    check("shln_rst:idle", obs4(), 16'b0000_0000_0000_0001);
    valid = 1'b1; opcode = 4'b1001; arg = 4'd4;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("shln_rst:run1", obs4(), 16'b000_011_000_000_1_0_0_0);
    @(negedge clk);
    check("shln_rst:run2", obs4(), 16'b000_011_000_000_1_0_0_0);
    rst = 1'b1;
    @(negedge clk);
    check("shln_rst:abort", obs4(), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    run_instr(4'b0111, 4'd0, 0, "sub_after_rst");

    for (int k = 0; k < 30; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      run_instr(rop, ra, $urandom_range(0, int'(ra) + 1), "random");
    end

    // Wide-opcode instance: high bits make an otherwise valid ADD illegal.
    check("w6:idle", obs6(), 16'b0000_0000_0000_0001);
    valid6 = 1'b1; opcode6 = 6'b010011; arg6 = 4'd0;
    @(posedge clk);
    @(negedge clk);
    valid6 = 1'b0;
    check("w6:illegal_done", obs6(), 16'b000_000_000_000_1_1_1_0);
    @(negedge clk);
    check("w6:idle2", obs6(), 16'b0000_0000_0000_0001);
    valid6 = 1'b1; opcode6 = 6'b000011;
    @(posedge clk);
    @(negedge clk);
    valid6 = 1'b0;
    check("w6:add_run", obs6(), 16'b000_001_000_000_1_0_0_0);
    @(negedge clk);
    check("w6:add_done", obs6(), 16'b000_000_000_000_1_1_0_0);
    @(negedge clk);
    check("w6:idle3", obs6(), 16'b0000_0000_0000_0001);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/unidade_controle_seq.md
# unidade_controle_seq

Sequenced, parametrised control unit for the datapath with registers X, Y and Z. It accepts one instruction at a time over a valid/ready handshake and drives the per-register control codes Tx/Ty/Tz and the ALU select tula. Beyond the single-cycle opcodes, it supports repeated operations (N-fold shifts, N-fold add) and a status-terminated add loop driven by an iteration counter. It sits between the instruction source and the register/ALU datapath.

## Interface
- OPW, 4: opcode width; must be ≥4. Any nonzero bit above bit 3 makes the opcode illegal.
- CNTW, 4: width of the repeat count `arg` and the internal counter.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- instr_valid  in  1  an instruction is presented.
- instr_ready  out  1  high only in IDLE with rst low; the instruction is accepted when valid&&ready.
- opcode  in  OPW  instruction code.
- arg  in  CNTW  repeat count for the repeat opcodes; ignored otherwise.
- status  in  1  ALU flag used by ADDZ (1 = terminate).
- Tx, Ty, Tz  out  3  register control: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100.
- tula  out  3  ALU op: ADD 000, SUB 001; 000 when idle.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.

## Operation
- Opcodes and the control word each asserts. Registers not listed are HOLD; tula is ADD unless stated.
  - 0000 NOP: all HOLD.
  - 0001 CLDRD: Y=RESET, X=LOAD, Z=RESET.
  - 0010 ADDLD: Y=LOAD, X=LOAD.
  - 0011 ADD: Y=LOAD.
  - 0100 DIV2: Y=SHIFTR.
  - 0101 DISPLAY: Z=LOAD.
  - 0110 MUL2: Y=SHIFTL.
  - 0111 SUB: Y=LOAD, tula=SUB.
  - 1000 SHRN: Y=SHIFTR, repeated arg times.
  - 1001 SHLN: Y=SHIFTL, repeated arg times.
  - 1010 ADDN: Y=LOAD, repeated arg times.
  - 1011 ADDZ: Y=LOAD, repeated until status=1, at most arg times.
  - 1100–1111: illegal.
- FSM states are IDLE, RUN and DONE.
- IDLE: outputs all HOLD, instr_ready=1.
  - On acceptance of a single-cycle opcode, load cnt=1 and go to RUN.
  - On acceptance of a repeat opcode (1000–1011), load cnt=arg. If arg=0, go straight to DONE with no control action.
  - On acceptance of an illegal opcode, go to DONE and latch err.
- RUN: drive the latched control word.
  - At each edge, if cnt==1, or (op==ADDZ && status==1), go to DONE.
  - Otherwise decrement cnt and stay in RUN.
- DONE: outputs all HOLD, done=1, err=latched flag; next state IDLE.
- The opcode, arg and control word are latched at acceptance. Input changes during busy are ignored.
- A NOP still passes through RUN for one cycle with an all-HOLD word.

## Timing
- Reset: Tx=Ty=Tz=tula=000, busy=0, done=0, err=0, instr_ready=0 while rst=1. The state is IDLE on the first cycle after rst falls.
- rst asserted mid-operation aborts the operation on that edge. No done pulse is generated for the aborted instruction.
- Control outputs are registered. The control word first appears in the cycle after the acceptance edge.
- Cycle counts for a repeat opcode with count n≥1:
  - n cycles in RUN, then 1 in DONE, then IDLE.
  - The next acceptance is possible n+2 cycles after the previous one.
- Cycle counts for a single-cycle opcode: RUN for 1 cycle, DONE for 1 cycle.
- Illegal opcode or arg=0: DONE in the cycle after acceptance, then IDLE.
- ADDZ:
  - status is sampled at each RUN edge.
  - The control word of the cycle in which status=1 is sampled has already been applied. No further LOAD follows it.
  - If status=1 on the first RUN edge, exactly one LOAD is issued.
- arg=2^CNTW−1 gives that many repetitions; the counter never wraps.

## Structure
- Package unidade_controle_pkg holds:
  - register codes HOLD/LOAD/SHIFTR/SHIFTL/RESET;
  - tula codes ADD/SUB;
  - opcode constants;
  - the state enum;
  - a control-word struct {tx, ty, tz, tula}.
- Sub-module decodificador_instr: combinational, opcode → {control word, is_repeat, is_until, legal}. The FSM, counter and output registers stay in the top module.

## Test plan
- Reset, then ADD (0011) → exactly one cycle later Ty=001, other outputs 000; done pulses on the following cycle; instr_ready is back to 1 the cycle after that.
- CLDRD (0001) → one cycle with Ty=100, Tx=001, Tz=100, then all HOLD.
- SHRN with arg=3 → Ty=010 for exactly 3 consecutive cycles, then done; busy is high for 4 cycles. SHLN with arg=0 → no control action and done one cycle after acceptance.
- ADDZ with arg=5:
  - status rises during the 2nd RUN cycle → exactly 2 Ty=LOAD cycles.
  - status held 0 → 5 LOAD cycles.
- Opcode 1110 → no control action; done=err=1 for one cycle. With OPW=6, opcode 010011 → illegal.
- rst during the 2nd cycle of SHLN with arg=4 → next cycle all outputs 000, no done; then a new SUB is accepted → Ty=001, tula=001.
